// File: rtl/cpu_fetch_q.sv
// cpu_fetch_q: instruction fetch unit for the cpu16 core.
// Keeps up to MAX_OUT in-order reads in flight to instruction memory and
// buffers returned words in a DEPTH-entry prefetch queue for decode.
// A branch redirect flushes the queue and discards wrong-path responses
// that are still in flight.

// Protocol checker: memory may only respond while a read is outstanding,
// and the discard counter can never exceed the in-flight count.
module cpu_fetch_q_chk #(
  parameter int OW = 2
) (
  input logic          clk,
  input logic          reset,
  input logic          ins_rd_rdy,
  input logic [OW-1:0] outstanding,
  input logic [OW-1:0] drop
);

  rsp_needs_outstanding: assert property (
    @(posedge clk) disable iff (reset)
      !(ins_rd_rdy && (outstanding == {OW{1'b0}})));

  drop_bounded: assert property (
    @(posedge clk) disable iff (reset)
      (drop <= outstanding));

endmodule

module cpu_fetch_q #(
  parameter int            AW       = 16,
  parameter int            DW       = 16,
  parameter int            DEPTH    = 4,
  parameter int            MAX_OUT  = 2,
  parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] ins_rd_addr,
  output logic          ins_rd_req,
  input  logic          ins_rd_gnt,
  input  logic [DW-1:0] ins_rd_data,
  input  logic          ins_rd_rdy,
  output logic [DW-1:0] ir_data,
  output logic [AW-1:0] ir_pc,
  output logic          ir_valid,
  input  logic          ir_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc
);

  localparam int QW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int SW = CW + OW;

  // Fetch pointer and prefetch queue storage
  logic [AW-1:0] fetch_pc;
  logic [DW-1:0] q_data [DEPTH];
  logic [AW-1:0] q_pc   [DEPTH];
  logic [QW-1:0] rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
  logic [CW-1:0] count, count_n, count_after_pop;

  // In-flight tracking: issued addresses travel alongside the memory pipe
  logic [AW-1:0] tag_mem [MAX_OUT];
  logic [TW-1:0] tag_wr, tag_rd;
  logic [AW-1:0] tag_head;
  logic [OW-1:0] outstanding, outstanding_n;
  logic [OW-1:0] drop, drop_n;

  logic [SW-1:0] credit_sum;
  logic          accept, rsp, push, pop;
  logic [DW-1:0] head_data_n;
  logic [AW-1:0] head_pc_n;

  // Advance a tag FIFO pointer, wrapping at MAX_OUT (not necessarily a power of 2)
  function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] ptr);
    if (ptr == TW'(MAX_OUT - 1)) begin
      return {TW{1'b0}};
    end else begin
      return ptr + TW'(1);
    end
  endfunction

  assign ins_rd_addr = fetch_pc;
  assign tag_head    = tag_mem[tag_rd];

  // Credit-based issue, handshakes and next-state bookkeeping
  always_comb begin
    credit_sum = SW'(count) + SW'(outstanding);
    // Queue slots are reserved at issue time so a response always has room
    ins_rd_req = !reset && !redirect &&
                 (credit_sum < SW'(DEPTH)) &&
                 (outstanding < OW'(MAX_OUT));
    accept = ins_rd_req && ins_rd_gnt;
    // A response with nothing in flight is a protocol error and is ignored
    rsp    = ins_rd_rdy && (outstanding != {OW{1'b0}});
    push   = rsp && (drop == {OW{1'b0}}) && !redirect;
    pop    = ir_valid && ir_ready && !redirect;

    if (pop) begin
      count_after_pop = count - CW'(1);
    end else begin
      count_after_pop = count;
    end

    if (redirect) begin
      count_n  = {CW{1'b0}};
      rd_ptr_n = {QW{1'b0}};
      wr_ptr_n = {QW{1'b0}};
    end else begin
      count_n  = push ? (count_after_pop + CW'(1)) : count_after_pop;
      rd_ptr_n = pop  ? (rd_ptr + QW'(1)) : rd_ptr;
      wr_ptr_n = push ? (wr_ptr + QW'(1)) : wr_ptr;
    end

    // When the queue drains to nothing, an arriving word becomes the head directly
    if (push && (count_after_pop == {CW{1'b0}})) begin
      head_data_n = ins_rd_data;
      head_pc_n   = tag_head;
    end else begin
      head_data_n = q_data[rd_ptr_n];
      head_pc_n   = q_pc[rd_ptr_n];
    end

    if (accept && !rsp) begin
      outstanding_n = outstanding + OW'(1);
    end else if (!accept && rsp) begin
      outstanding_n = outstanding - OW'(1);
    end else begin
      outstanding_n = outstanding;
    end

    // On redirect every read still in flight after this cycle is wrong-path;
    // a response arriving in the redirect cycle is discarded by !redirect above
    if (redirect) begin
      drop_n = rsp ? (outstanding - OW'(1)) : outstanding;
    end else if (rsp && (drop != {OW{1'b0}})) begin
      drop_n = drop - OW'(1);
    end else begin
      drop_n = drop;
    end
  end

  // Control state, pointers and registered decode-side outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rd_ptr      <= {QW{1'b0}};
      wr_ptr      <= {QW{1'b0}};
      count       <= {CW{1'b0}};
      tag_wr      <= {TW{1'b0}};
      tag_rd      <= {TW{1'b0}};
      outstanding <= {OW{1'b0}};
      drop        <= {OW{1'b0}};
      ir_valid    <= 1'b0;
      ir_data     <= {DW{1'b0}};
      ir_pc       <= {AW{1'b0}};
    end else begin
      if (redirect) begin
        fetch_pc <= redirect_pc;
      end else if (accept) begin
        fetch_pc <= fetch_pc + AW'(1);
      end else begin
        fetch_pc <= fetch_pc;
      end
      tag_wr      <= accept ? tag_next(tag_wr) : tag_wr;
      tag_rd      <= rsp ? tag_next(tag_rd) : tag_rd;
      rd_ptr      <= rd_ptr_n;
      wr_ptr      <= wr_ptr_n;
      count       <= count_n;
      outstanding <= outstanding_n;
      drop        <= drop_n;
      ir_valid    <= (count_n != {CW{1'b0}});
      ir_data     <= head_data_n;
      ir_pc       <= head_pc_n;
    end
  end

  // Queue and tag storage writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= {DW{1'b0}};
        q_pc[i]   <= {AW{1'b0}};
      end
      for (int j = 0; j < MAX_OUT; j++) begin
        tag_mem[j] <= {AW{1'b0}};
      end
    end else begin
      if (push) begin
        q_data[wr_ptr] <= ins_rd_data;
        q_pc[wr_ptr]   <= tag_head;
      end else begin
        q_data[wr_ptr] <= q_data[wr_ptr];
      end
      if (accept) begin
        tag_mem[tag_wr] <= fetch_pc;
      end else begin
        tag_mem[tag_wr] <= tag_mem[tag_wr];
      end
    end
  end

  cpu_fetch_q_chk #(.OW(OW)) u_chk (
    .clk         (clk),
    .reset       (reset),
    .ins_rd_rdy  (ins_rd_rdy),
    .outstanding (outstanding),
    .drop        (drop)
  );

endmodule
